// File: rtl/axis_sobol_2d_source.sv
`default_nettype none
// ============================================================================
//  Module      : axis_sobol_2d_source
//  Description : 2-D Sobol point generator (dims 0/1, Gray-code order) on an
//                AXI-Stream master, one 64-bit point per beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_sobol_2d_source #(
    parameter int DIMS                   = 2,
    parameter int FRAC_BITS              = 32,
    parameter int INDEX_BITS             = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = DIMS * FRAC_BITS
) (
    input  logic                                  m00_axis_aclk,
    input  logic                                  m00_axis_aresetn,
    input  logic                                  start,
    input  logic [INDEX_BITS-1:0]                 start_index,
    input  logic [INDEX_BITS-1:0]                 num_samples,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  m00_axis_tvalid,
    input  logic                                  m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic                                  m00_axis_tlast,
    output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
    output logic [INDEX_BITS-1:0]                 sample_index
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_run  = 2'd2;

    // Dimension-1 direction vectors packed as 32 x 32-bit words, word k = v1[k].
    function automatic logic [1023:0] f_v1_table();
        logic [1023:0] t;
        logic [31:0]   v;
        t = '0;
        v = 32'h8000_0000;
        for (int k = 0; k < 32; k++) begin
            t[k*32 +: 32] = v;
            v             = v ^ (v >> 1);
        end
        return t;
    endfunction

    localparam logic [1023:0] c_v1_table = f_v1_table();

    logic [1:0]            r_state;
    logic [INDEX_BITS-1:0] r_start_index;
    logic [INDEX_BITS-1:0] r_num_samples;
    logic [INDEX_BITS-1:0] r_sample_index;
    logic [INDEX_BITS-1:0] r_remaining;
    logic [31:0]           r_u0;
    logic [31:0]           r_u1;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic                  r_done;

    logic [31:0]           w_start32;
    logic [31:0]           w_gray;
    logic [31:0]           w_load_u0;
    logic [31:0]           w_load_u1;
    logic [INDEX_BITS-1:0] w_next_index;
    logic [31:0]           w_next32;
    logic [4:0]            w_c;
    logic [31:0]           w_v0_step;
    logic [31:0]           w_v1_step;
    logic                  w_handshake;

    assign w_start32    = 32'(r_start_index);
    assign w_next_index = r_sample_index + INDEX_BITS'(1);
    assign w_next32     = 32'(w_next_index);
    assign w_handshake  = r_tvalid & m00_axis_tready;

    // Direct point: XOR of the direction vectors selected by the Gray code bits.
    always_comb begin
        w_gray    = w_start32 ^ (w_start32 >> 1);
        w_load_u0 = '0;
        w_load_u1 = '0;
        for (int j = 0; j < 32; j++) begin
            if (w_gray[j]) begin
                w_load_u0 = w_load_u0 ^ (32'h8000_0000 >> j);
                w_load_u1 = w_load_u1 ^ c_v1_table[j*32 +: 32];
            end
        end
    end

    // Lowest set bit wins; an all-zero index (wrap) selects vector 31.
    always_comb begin
        w_c = 5'd31;
        for (int i = 31; i >= 0; i--) begin
            if (w_next32[i]) begin
                w_c = 5'(i);
            end
        end
    end

    assign w_v0_step = 32'h8000_0000 >> w_c;
    assign w_v1_step = c_v1_table[{w_c, 5'b00000} +: 32];

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            r_state        <= c_st_idle;
            r_start_index  <= '0;
            r_num_samples  <= '0;
            r_sample_index <= '0;
            r_remaining    <= '0;
            r_u0           <= '0;
            r_u1           <= '0;
            r_tvalid       <= 1'b0;
            r_tlast        <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    // A start coinciding with the done pulse belongs to the batch just finished.
                    if (start && !r_done) begin
                        r_start_index <= start_index;
                        r_num_samples <= num_samples;
                        if (num_samples == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= c_st_load;
                        end
                    end
                end
                c_st_load: begin
                    r_u0           <= w_load_u0;
                    r_u1           <= w_load_u1;
                    r_sample_index <= r_start_index;
                    r_remaining    <= r_num_samples;
                    r_tlast        <= (r_num_samples == INDEX_BITS'(1));
                    r_tvalid       <= 1'b1;
                    r_state        <= c_st_run;
                end
                c_st_run: begin
                    if (w_handshake) begin
                        if (r_tlast) begin
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= c_st_idle;
                        end else begin
                            r_u0           <= r_u0 ^ w_v0_step;
                            r_u1           <= r_u1 ^ w_v1_step;
                            r_sample_index <= w_next_index;
                            r_remaining    <= r_remaining - INDEX_BITS'(1);
                            r_tlast        <= (r_remaining == INDEX_BITS'(2));
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign busy            = (r_state == c_st_load) || (r_state == c_st_run);
    assign done            = r_done;
    assign m00_axis_tvalid = r_tvalid;
    assign m00_axis_tlast  = r_tlast;
    assign m00_axis_tdata  = C_M00_AXIS_TDATA_WIDTH'({r_u1, r_u0});
    assign m00_axis_tstrb  = '1;
    assign sample_index    = r_sample_index;

endmodule
`default_nettype wire
